// File: rtl/sram_rmw_ctrl.sv
// sram_rmw_ctrl: valid/ready request front end for a 1RW SRAM without byte enables.
// Partial writes become a read cycle followed by a merged write cycle.
module sram_rmw_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_be_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_we_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  sram_we_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        RD_CAP,
        RMW_WR
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                  r_rsp_valid;
    logic                  r_rsp_we;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [BE_WIDTH-1:0]   r_be;

    logic                  w_rsp_free;
    logic                  w_accept;
    logic                  w_be_full;
    logic                  w_be_zero;
    logic                  w_load;
    logic                  w_load_we;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic [DATA_WIDTH-1:0] w_merge;
    logic                  w_sram_we;
    logic [ADDR_WIDTH-1:0] w_sram_addr;
    logic [DATA_WIDTH-1:0] w_sram_wdata;

    // The slot may drain on the same edge a new request is accepted.
    assign w_rsp_free  = !r_rsp_valid || rsp_ready_i;
    assign req_ready_o = (r_state == IDLE) && w_rsp_free;
    assign w_accept    = req_valid_i && req_ready_o;
    assign w_be_full   = &req_be_i;
    assign w_be_zero   = ~|req_be_i;

    always_comb begin
        w_merge = sram_rdata_i;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (r_be[i]) begin
                w_merge[8*i +: 8] = r_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        w_sram_we    = 1'b0;
        w_sram_addr  = '0;
        w_sram_wdata = '0;
        w_load       = 1'b0;
        w_load_we    = 1'b0;
        w_load_data  = '0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_sram_addr = req_addr_i;
                    if (!req_we_i) begin
                        w_next = RD_CAP;
                    end else if (w_be_full) begin
                        w_sram_we    = 1'b1;
                        w_sram_wdata = req_wdata_i;
                        w_load       = 1'b1;
                        w_load_we    = 1'b1;
                    end else if (w_be_zero) begin
                        w_load    = 1'b1;
                        w_load_we = 1'b1;
                    end else begin
                        w_next = RMW_WR;
                    end
                end
            end
            RD_CAP: begin
                w_load      = 1'b1;
                w_load_data = sram_rdata_i;
                w_next      = IDLE;
            end
            RMW_WR: begin
                w_sram_we    = 1'b1;
                w_sram_addr  = r_addr;
                w_sram_wdata = w_merge;
                w_load       = 1'b1;
                w_load_we    = 1'b1;
                w_next       = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (w_accept) begin
            r_addr  <= req_addr_i;
            r_wdata <= req_wdata_i;
            r_be    <= req_be_i;
        end
    end

    // A new response loading on the draining edge takes the slot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rsp_valid <= 1'b0;
            r_rsp_we    <= 1'b0;
            r_rsp_rdata <= '0;
        end else if (w_load) begin
            r_rsp_valid <= 1'b1;
            r_rsp_we    <= w_load_we;
            r_rsp_rdata <= w_load_data;
        end else if (r_rsp_valid && rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_we_o     = r_rsp_we;
    assign rsp_rdata_o  = r_rsp_rdata;

    // Reset masks the SRAM port so an abandoned RMW never writes.
    assign sram_we_o    = w_sram_we && !rst_i;
    assign sram_addr_o  = rst_i ? '0 : w_sram_addr;
    assign sram_wdata_o = rst_i ? '0 : w_sram_wdata;

endmodule

// File: doc/sram_rmw_ctrl.md
Name: sram_rmw_ctrl

Overview:
- Initiator side of the 1RW single-port SRAM interface: converts valid/ready read/write requests with byte enables into SRAM port cycles.
- The SRAM port has no byte enables, so partial writes are done as a read-modify-write: read cycle, then merged write cycle.
- Returns one response per request through a single-entry response register with backpressure.
- Sits between a cache pipeline (data/tag array client) and the SRAM macro.

Parameters:
- DATA_WIDTH, 64, SRAM word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10, SRAM word address width.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width; derived, not overridden.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&ready.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  ADDR_WIDTH  word address.
- req_wdata_i  in  DATA_WIDTH  write data.
- req_be_i  in  BE_WIDTH  byte enables; bit i covers bits [8i+7:8i].
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when valid&ready.
- rsp_we_o  out  1  echo of the request type.
- rsp_rdata_o  out  DATA_WIDTH  read data; 0 for write responses.
- sram_we_o  out  1  SRAM write enable.
- sram_addr_o  out  ADDR_WIDTH  SRAM address.
- sram_wdata_o  out  DATA_WIDTH  SRAM write data.
- sram_rdata_i  in  DATA_WIDTH  SRAM read data, valid the cycle after a read cycle.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, rsp_valid_o=0, rsp_we_o=0, rsp_rdata_o=0, sram_we_o=0, sram_wdata_o=0, sram_addr_o=0; holding registers cleared.
- States: IDLE, RD_CAP, RMW_WR.
- req_ready_o = (state==IDLE) && (!rsp_valid_o || rsp_ready_i). It is independent of req_valid_i and req_we_i.
- IDLE with no handshake: sram_we_o=0; sram_addr_o, sram_wdata_o don't-care.
- Read accepted in cycle T:
  - In T (combinational from the request): sram_we_o=0, sram_addr_o=req_addr_i. Next state RD_CAP.
  - In T+1 (RD_CAP): capture sram_rdata_i into rsp_rdata_o; rsp_we_o=0; rsp_valid_o=1 from T+2. Next state IDLE.
- Write, req_be_i all ones, accepted in T:
  - In T: sram_we_o=1, addr/wdata from the request.
  - rsp_valid_o=1 from T+1 with rsp_we_o=1, rsp_rdata_o=0. State stays IDLE.
- Write, req_be_i==0, accepted in T: no SRAM write (sram_we_o=0). Ack response from T+1 as above.
- Write, partial req_be_i, accepted in T:
  - In T: read cycle (sram_we_o=0, addr=req_addr_i). Latch addr, wdata, be. Next state RMW_WR.
  - In T+1 (RMW_WR): sram_we_o=1, sram_addr_o=latched addr.
  - Merge per byte: sram_wdata_o byte i = be[i] ? latched wdata byte i : sram_rdata_i byte i.
  - Ack rsp_valid_o=1 from T+2. Next state IDLE.
- The controller never uses sram_rdata_i from a write cycle; the SRAM's read-during-write behaviour is irrelevant to it.
- Response register:
  - rsp_valid_o stays 1 and rsp_we_o/rsp_rdata_o stay stable until rsp_valid_o&&rsp_ready_i.
  - On the handshake cycle a new request may be accepted (slot drains the same edge).
  - A response loading in the same edge the old one drains wins: valid stays 1 with the new data.
- Throughput with rsp_ready_i=1: full/zero-BE writes 1 per cycle; reads and partial writes 1 per 2 cycles.
- sram_we_o is 1 only in a full-write accept cycle or in RMW_WR; it never asserts while rst_i=1.
- Reset mid-operation (RD_CAP or RMW_WR): the operation is abandoned and no SRAM write occurs.
  - The pending response is dropped; rsp_valid_o=0 the cycle after reset is sampled.
  - SRAM contents are unchanged by the abandoned RMW.

Test Plan:
- Preload addr 0x010=0x1122334455667788. Read 0x010 accepted at T, rsp_ready_i=1 -> rsp_valid_o at T+2, rsp_rdata_o=0x1122334455667788, rsp_we_o=0; req_ready_o=0 in T+1.
- Full write 0x020=0xDEADBEEFCAFEF00D (be=0xFF) at T -> sram_we_o=1 only in T; ack at T+1. Read 0x020 returns the written value.
- Partial write to 0x010, be=0x0F, wdata=0xAAAAAAAABBBBBBBB -> read cycle T, write cycle T+1 with sram_wdata_o=0x11223344BBBBBBBB; ack at T+2. Read-back matches.
- Backpressure: read response pending with rsp_ready_i=0 for 5 cycles -> rsp_rdata_o stable, req_ready_o=0 throughout. When rsp_ready_i=1: same-cycle accept of the next request, no response lost or duplicated.
- be=0x00 write to 0x010 -> sram_we_o never 1, ack at T+1, memory unchanged.
- Assert rst_i during RMW_WR of a be=0x01 write to 0x030 (preload 0x0) -> sram_we_o=0 that cycle, rsp_valid_o=0 after reset, read of 0x030 returns 0x0.
